// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router defaults, buffer entry struct and occupancy states
package router_pkg;

    localparam int NO_OUTPORT = 6;
    localparam int NO_VC      = 13;
    localparam int VC_W       = 4;
    localparam int PHIT_SIZE  = 16;

    typedef struct packed {
        logic [PHIT_SIZE-1:0] phit;
        logic                 new_f;
        logic                 sent_req;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/inport_out_stage_if.sv
// rtl/inport_out_stage_if.sv - registered phit valid/ready handshake toward the outport
interface inport_out_stage_if #(
    parameter int PHIT_SIZE = router_pkg::PHIT_SIZE
);
    logic [PHIT_SIZE-1:0] outdata;
    logic                 new_flag;
    logic                 sent_req;
    logic                 out_valid;
    logic                 out_rdy;

    modport master (output outdata, new_flag, sent_req, out_valid, input out_rdy);
    modport slave  (input outdata, new_flag, sent_req, out_valid, output out_rdy);
endinterface

// File: rtl/skid_buffer2.sv
// rtl/skid_buffer2.sv - 2-entry FIFO with wrap-around 1-bit pointers and EMPTY/ONE/FULL occupancy
module skid_buffer2
    import router_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occupancy
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    occ_e         occ_q, occ_d;
    logic         push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (occ_q != OCC_FULL);
        pop_ok   = pop && (occ_q != OCC_EMPTY);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case (occ_q)
            OCC_EMPTY: if (push_ok) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push_ok && !pop_ok)      occ_d = OCC_FULL;
                else if (pop_ok && !push_ok) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop_ok) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= OCC_EMPTY;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/inport_out_stage.sv
// rtl/inport_out_stage.sv - per-outport output stage: grant accept, VC strobe, skid-buffered phit
// Optional phit_count statistics port enabled by INPORT_OUT_STATS_EN.
module inport_out_stage #(
    parameter int NO_OUTPORT = router_pkg::NO_OUTPORT,
    parameter int NO_VC      = router_pkg::NO_VC,
    parameter int VC_W       = router_pkg::VC_W,
    parameter int PHIT_SIZE  = router_pkg::PHIT_SIZE,
    parameter int IDEN_NO    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [VC_W-1:0]            invc_no_from_outport,
    input  logic [NO_VC*PHIT_SIZE-1:0] outdatas,
    input  logic [NO_VC-1:0]           news,
    input  logic [NO_VC-1:0]           sent_reqs,
    input  logic                       ok,
    input  logic                       ready,
    input  logic                       in_update,
    input  logic [NO_VC-1:0]           in_allowed_vcs,
    input  logic [VC_W-1:0]            invc_req_no_from_in,
    inport_out_stage_if.master         out_if,
    output logic [NO_VC-1:0]           call_invc,
    output logic [NO_OUTPORT-1:0]      ok_vec,
    output logic [NO_OUTPORT-1:0]      ready_vec,
    output logic [1:0]                 occupancy,
    output logic                       err_bad_vc,
    output logic                       out_update,
    output logic [NO_VC-1:0]           out_allowed_vcs,
    output logic [VC_W-1:0]            invc_req_no_to_out
`ifdef INPORT_OUT_STATS_EN
    ,
    output logic [31:0]                phit_count
`endif
);
    localparam int ENTRY_W = PHIT_SIZE + 2;

    logic               vc_in_range;
    logic               not_full;
    logic               accept;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               err_bad_vc_q, err_bad_vc_d;

    // Acceptance ignores same-cycle pops so out_rdy never reaches call_invc combinationally.
    always_comb begin
        vc_in_range  = int'(invc_no_from_outport) < NO_VC;
        not_full     = occupancy != 2'd2;
        accept       = !rst && en && not_full && vc_in_range;
        pop          = out_if.out_valid && out_if.out_rdy;
        call_invc    = accept ? (NO_VC'(1) << invc_no_from_outport) : '0;
        err_bad_vc_d = en && !vc_in_range;
        push_entry   = '0;
        for (int i = 0; i < NO_VC; i++) begin
            if (int'(invc_no_from_outport) == i) begin
                push_entry = {outdatas[i*PHIT_SIZE +: PHIT_SIZE], news[i], sent_reqs[i]};
            end
        end
    end

    skid_buffer2 #(.W(ENTRY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) err_bad_vc_q <= 1'b0;
        else     err_bad_vc_q <= err_bad_vc_d;
    end

    assign err_bad_vc       = err_bad_vc_q;
    assign out_if.out_valid = occupancy != 2'd0;
    assign out_if.outdata   = out_if.out_valid ? head_entry[ENTRY_W-1:2] : '0;
    assign out_if.new_flag  = out_if.out_valid & head_entry[1];
    assign out_if.sent_req  = out_if.out_valid & head_entry[0];

    assign ok_vec    = ok ? (NO_OUTPORT'(1) << IDEN_NO) : '0;
    assign ready_vec = (ready && not_full) ? (NO_OUTPORT'(1) << IDEN_NO) : '0;

    assign out_update         = in_update;
    assign out_allowed_vcs    = in_allowed_vcs;
    assign invc_req_no_to_out = invc_req_no_from_in;

`ifdef INPORT_OUT_STATS_EN
    logic [31:0] phit_count_q, phit_count_d;

    always_comb phit_count_d = phit_count_q + {31'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) phit_count_q <= '0;
        else     phit_count_q <= phit_count_d;
    end

    assign phit_count = phit_count_q;
`endif

endmodule

// File: tb/tb_inport_out_stage.sv
// tb/tb_inport_out_stage.sv - randomized bench against a queue model of the output stage
module tb_inport_out_stage;
    import router_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic [3:0]           invc = '0;
    logic [13*16-1:0]     outdatas = '0;
    logic [12:0]          news = '0, sent_reqs = '0;
    logic                 ok = 1'b0, ready = 1'b0;
    logic                 in_update = 1'b0;
    logic [12:0]          in_allowed_vcs = '0;
    logic [3:0]           invc_req_no_from_in = '0;
    logic [12:0]          call_invc;
    logic [5:0]           ok_vec, ready_vec;
    logic [1:0]           occupancy;
    logic                 err_bad_vc;
    logic                 out_update;
    logic [12:0]          out_allowed_vcs;
    logic [3:0]           invc_req_no_to_out;
`ifdef INPORT_OUT_STATS_EN
    logic [31:0]          phit_count;
`endif

    inport_out_stage_if #(.PHIT_SIZE(16)) out_if ();

    inport_out_stage #(.NO_OUTPORT(6), .NO_VC(13), .VC_W(4), .PHIT_SIZE(16), .IDEN_NO(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .en                   (en),
        .invc_no_from_outport (invc),
        .outdatas             (outdatas),
        .news                 (news),
        .sent_reqs            (sent_reqs),
        .ok                   (ok),
        .ready                (ready),
        .in_update            (in_update),
        .in_allowed_vcs       (in_allowed_vcs),
        .invc_req_no_from_in  (invc_req_no_from_in),
        .out_if               (out_if),
        .call_invc            (call_invc),
        .ok_vec               (ok_vec),
        .ready_vec            (ready_vec),
        .occupancy            (occupancy),
        .err_bad_vc           (err_bad_vc),
        .out_update           (out_update),
        .out_allowed_vcs      (out_allowed_vcs),
        .invc_req_no_to_out   (invc_req_no_to_out)
`ifdef INPORT_OUT_STATS_EN
        ,
        .phit_count           (phit_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    entry_t      q[$];
    logic        err_exp = 1'b0;
    int unsigned pops_exp = 0;
    bit          hold_data = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle, check against the queue model, then advance model and clock.
    task automatic step(input logic r, input logic e, input logic [3:0] vc, input logic rdy);
        bit     acc;
        entry_t ent;
        rst = r; en = e; invc = vc; out_if.out_rdy = rdy;
        ok = 1'($urandom); ready = 1'($urandom);
        in_update = 1'($urandom); in_allowed_vcs = 13'($urandom); invc_req_no_from_in = 4'($urandom);
        if (!hold_data) begin
            for (int i = 0; i < 13; i++) outdatas[i*16 +: 16] = 16'($urandom);
            news = 13'($urandom);
            sent_reqs = 13'($urandom);
        end
        #1;
        acc = !r && e && (vc < 13) && (q.size() < 2);
        chk("call_invc", call_invc, acc ? (64'd1 << vc) : 64'd0);
        chk("out_valid", out_if.out_valid, q.size() != 0);
        chk("outdata", out_if.outdata, q.size() != 0 ? q[0].phit : 16'd0);
        chk("new", out_if.new_flag, q.size() != 0 ? q[0].new_f : 1'b0);
        chk("sent_req", out_if.sent_req, q.size() != 0 ? q[0].sent_req : 1'b0);
        chk("occupancy", occupancy, q.size());
        chk("err_bad_vc", err_bad_vc, err_exp);
        chk("ok_vec", ok_vec, ok ? 6'b010000 : 6'b0);
        chk("ready_vec", ready_vec, (ready && q.size() < 2) ? 6'b010000 : 6'b0);
        chk("passthru", {out_update, out_allowed_vcs, invc_req_no_to_out},
            {in_update, in_allowed_vcs, invc_req_no_from_in});
`ifdef INPORT_OUT_STATS_EN
        chk("phit_count", phit_count, pops_exp);
`endif
        if (r) begin
            q.delete();
            err_exp = 1'b0;
            pops_exp = 0;
        end else begin
            if (q.size() != 0 && rdy) begin
                void'(q.pop_front());
                pops_exp++;
            end
            if (acc) begin
                ent.phit = outdatas[vc*16 +: 16];
                ent.new_f = news[vc];
                ent.sent_req = sent_reqs[vc];
                q.push_back(ent);
            end
            err_exp = e && (vc >= 13);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_if.out_rdy = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 4'd3, 1'b1);
        step(1'b1, 1'b1, 4'd3, 1'b1);

        hold_data = 1'b1;
        for (int i = 0; i < 13; i++) outdatas[i*16 +: 16] = 16'($urandom);
        outdatas[5*16 +: 16] = 16'hA5A5;
        news = 13'h0020;
        sent_reqs = 13'h0;
        step(1'b0, 1'b1, 4'd5, 1'b0);
        chk("single_outdata", out_if.outdata, 16'hA5A5);
        chk("single_new", out_if.new_flag, 1'b1);
        hold_data = 1'b0;
        step(1'b0, 1'b0, 4'd0, 1'b1);

        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd2, 1'b0);
        chk("bp_full", occupancy, 2'd2);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'(i % 13), 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        step(1'b0, 1'b1, 4'd13, 1'b1);
        chk("bad_vc_pulse", err_bad_vc, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("bad_vc_clear", err_bad_vc, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)), 1'($urandom));
        end

        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'(i), 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inport_out_stage.md
# inport_out_stage

Per-outport output stage of an input port: the parametrised successor of the input port's outport interface. It accepts the outport's VC grant, strobes the granted input VC, and captures that VC's phit into a 2-entry skid buffer. It presents the phit registered to the outport under a valid/ready handshake and drives the one-hot ok/ready status vectors. One instance sits per outport in each input port; downstream backpressure no longer drops phits.

## Interface
- NO_OUTPORT, 6, number of outports (width of status vectors)
- NO_VC, 13, virtual channels per input port
- VC_W, 4, width of VC index (floor(log2 NO_VC)+1)
- PHIT_SIZE, 16, phit width in bits
- IDEN_NO, 0, index of the outport served by this instance (0..NO_OUTPORT-1)

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  outport grant valid this cycle
- invc_no_from_outport  in  VC_W  granted input VC index
- outdatas  in  NO_VC*PHIT_SIZE  head phit of each VC, VC i at bits [(i+1)*PHIT_SIZE-1 : i*PHIT_SIZE]
- news, sent_reqs  in  NO_VC  per-VC head-flit / request-sent flags
- ok, ready  in  1  outport status bits
- out_rdy  in  1  outport accepts the presented phit
- in_update  in  1  pass-through, drives out_update
- in_allowed_vcs  in  NO_VC  pass-through, drives out_allowed_vcs
- invc_req_no_from_in  in  VC_W  pass-through, drives invc_req_no_to_out
- call_invc  out  NO_VC  one-hot pop strobe to the granted input VC
- ok_vec, ready_vec  out  NO_OUTPORT  status bit placed at position IDEN_NO, other bits 0
- outdata  out  PHIT_SIZE  head phit, zero when !out_valid
- new, sent_req  out  1  head flags, zero when !out_valid
- out_valid  out  1  skid buffer non-empty
- occupancy  out  2  entries held (0..2)
- err_bad_vc  out  1  one-cycle pulse on an out-of-range grant
- out_update, out_allowed_vcs, invc_req_no_to_out  out  as inputs  combinational pass-throughs

## Operation
- accept = en & (occupancy != 2) & (invc_no_from_outport < NO_VC).
- call_invc is the one-hot of invc_no_from_outport when accept is high, otherwise 0. The path is combinational, same cycle.
- On accept, push {outdatas[invc], news[invc], sent_reqs[invc]} at the buffer tail.
- pop = out_valid & out_rdy. The head advances and occupancy decrements.
- Simultaneous push and pop: occupancy is unchanged. A pop at occupancy 2 does not enable a push in the same cycle, so there is no combinational out_rdy-to-call_invc path.
- Occupancy states are EMPTY(0), ONE(1) and FULL(2):
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to FULL; pop without push goes to EMPTY; push with pop stays in ONE.
  - FULL: pop goes to ONE.
- en with invc_no_from_outport >= NO_VC: no strobe and no push. err_bad_vc pulses the next cycle.
- ok_vec = {NO_OUTPORT{ok}} & (1<<IDEN_NO). This is combinational.
- ready_vec = {NO_OUTPORT{ready & (occupancy != 2)}} & (1<<IDEN_NO). This is combinational.
- Buffer storage is two entries, each (PHIT_SIZE+2) bits wide, with 1-bit read and write pointers that wrap modulo 2.

## Timing
- Grant in cycle N produces the phit on outdata in cycle N+1. Latency is 1 cycle; throughput is 1 phit per cycle while out_rdy is held high.
- out_valid, outdata, new, sent_req and occupancy are registered, driven from the head entry.
- Reset values: occupancy=0, out_valid=0, outdata=0, new=0, sent_req=0, err_bad_vc=0, pointers=0, counter=0.
- call_invc, ok_vec and ready_vec are combinational. call_invc is 0 during rst.
- Reset asserted mid-operation discards buffered phits. No call_invc is issued in the reset cycle.

## Configuration
- INPORT_OUT_STATS_EN defined: adds output port phit_count (32 bits). It increments on every pop, wraps at 2^32, and resets to 0.
- INPORT_OUT_STATS_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package (router_pkg) holds the defaults NO_VC, VC_W and PHIT_SIZE, plus the buffer entry struct {phit, new, sent_req}.
- One sub-module: skid_buffer2, a 2-entry FIFO with push/pop/occupancy, parametrised on entry width.
- The one-hot decode is inline. The existing decoder module is not instantiated.

## Test plan
- Reset: drive rst for 2 cycles with en=1, VC 3 granted -> call_invc=0 and all registered outputs 0 throughout.
- Single grant: en=1, VC 5, outdatas[5]=16'hA5A5, news[5]=1 in cycle N -> call_invc=13'h0020 in N; outdata=16'hA5A5, new=1, out_valid=1 in N+1.
- Backpressure: out_rdy=0 with grants on VC 1 then VC 2 -> occupancy reaches 2, ready_vec=0, and a third grant gives call_invc=0. Then out_rdy=1 -> VC1 then VC2 phits emerge in order.
- Streaming: en=1 and out_rdy=1 for 20 cycles over VCs 0..12 -> 20 phits out in order, occupancy stays at 1, no loss.
- Bad VC: en=1, invc_no=13 -> call_invc=0, no push, err_bad_vc=1 for exactly one cycle.
- IDEN_NO=4, ok=1, ready=1, buffer not full -> ok_vec=ready_vec=6'b010000. With INPORT_OUT_STATS_EN, 7 pops -> phit_count=7.
